// File: rtl/arb_pkg.sv
// Shared types and sizing helpers for the round-robin index arbiter.
// The grant register is either empty or holding one live grant.
package arb_pkg;

   function automatic int IDX_W(input int n);
      return $clog2(n);
   endfunction

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } arb_state_t;

endpackage

// File: rtl/rr_index_arbiter_pick.sv
// Combinational rotating-priority picker: the first set request at or above ptr,
// falling back to the lowest set request overall when nothing sits at or above ptr.
module rr_pick
   import arb_pkg::*;
#(
   parameter int N_REQ     = 8,
   parameter int IDX_WIDTH = 3
) (
   input  logic [N_REQ-1:0]     req,
   input  logic [IDX_WIDTH-1:0] ptr,
   output logic                 any,
   output logic [IDX_WIDTH-1:0] winner
);

   logic [N_REQ-1:0]     below_ptr;
   logic [N_REQ-1:0]     upper_req;
   logic [IDX_WIDTH-1:0] upper_idx;
   logic [IDX_WIDTH-1:0] lower_idx;

   // below_ptr is (1<<ptr)-1; masking it off leaves the requests from ptr upward.
   always_comb begin
      below_ptr = '0;
      for (int i = 0; i < N_REQ; i++) begin
         below_ptr[i] = (i < int'(ptr));
      end
      upper_req = req & ~below_ptr;
   end

   always_comb begin
      upper_idx = '0;
      lower_idx = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (upper_req[i]) upper_idx = IDX_WIDTH'(i);
         if (req[i])       lower_idx = IDX_WIDTH'(i);
      end
   end

   assign any    = |req;
   assign winner = (|upper_req) ? upper_idx : lower_idx;

endmodule

// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter emitting the winner as a registered binary index.
// The grant is held while the consumer stalls; ptr advances past each loaded winner.
module rr_index_arbiter
   import arb_pkg::*;
#(
   parameter int N_REQ     = 8,
   parameter int IDX_WIDTH = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req,
   output logic                 grant_valid,
   output logic [IDX_WIDTH-1:0] grant_idx,
   input  logic                 grant_ready,
   output logic [IDX_WIDTH-1:0] ptr
);

   if (N_REQ < 2 || N_REQ > 256) begin : g_bad_n_req
      $error("rr_index_arbiter: N_REQ must be in 2..256");
   end
   if (IDX_WIDTH != IDX_W(N_REQ)) begin : g_bad_idx_width
      $error("rr_index_arbiter: IDX_WIDTH must equal $clog2(N_REQ)");
   end

   arb_state_t           state_q, state_d;
   logic [IDX_WIDTH-1:0] grant_idx_q, grant_idx_d;
   logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
   logic                 pick_any;
   logic [IDX_WIDTH-1:0] pick_winner;
   logic                 load;

   rr_pick #(
      .N_REQ    (N_REQ),
      .IDX_WIDTH(IDX_WIDTH)
   ) u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .any   (pick_any),
      .winner(pick_winner)
   );

   // Valid/ready: a grant is offered while FULL and is consumed on any edge where
   // grant_ready is high; an empty register (or a consumed one) reloads from req.
   assign load = (state_q == EMPTY) || grant_ready;

   always_comb begin
      state_d     = state_q;
      grant_idx_d = grant_idx_q;
      ptr_d       = ptr_q;
      if (load) begin
         if (pick_any) begin
            state_d     = FULL;
            grant_idx_d = pick_winner;
            // Wrap at N_REQ-1 so ptr never names a non-existent requester.
            ptr_d       = (pick_winner == IDX_WIDTH'(N_REQ - 1)) ? '0 : pick_winner + 1'b1;
         end else begin
            state_d = EMPTY;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         grant_idx_q <= '0;
         ptr_q       <= '0;
      end else begin
         state_q     <= state_d;
         grant_idx_q <= grant_idx_d;
         ptr_q       <= ptr_d;
      end
   end

   assign grant_valid = (state_q == FULL);
   assign grant_idx   = grant_idx_q;
   assign ptr         = ptr_q;

endmodule
